reg_file_sb: RTL and testbench

Parametrised multi-read-port register file with a load scoreboard. It is the register file for the next-generation datapath, which adds multicycle memory loads. Provides NUM_RD combinational read ports and one priority write port from writeback. A second, handshaked write port takes load returns. A per-register busy bit tells decode to stall on registers with outstanding loads.

---
 rtl/reg_file_sb_pkg.sv | 31 +++
 rtl/reg_file_sb_if.sv | 37 +++
 rtl/reg_file_sb_scoreboard.sv | 61 ++++++
 rtl/reg_file_sb.sv | 83 ++++++++
 tb/tb_reg_file_sb.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb shared package: default sizes, zero-register index,
// and the next-busy-vector helper used by the load scoreboard.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  // Helper works on a fixed wide vector; callers zero-extend.
  localparam int MAX_AW    = 10;
  localparam int MAX_DEPTH = 1 << MAX_AW;

  function automatic logic [MAX_DEPTH-1:0] next_busy(
    input logic [MAX_DEPTH-1:0] busy,
    input logic                 iss_en,
    input logic [MAX_AW-1:0]    iss_reg,
    input logic                 ret_en,
    input logic [MAX_AW-1:0]    ret_reg
  );
    logic [MAX_DEPTH-1:0] nb;
    nb = busy;
    if (ret_en && ret_reg != MAX_AW'(ZERO_REG))
      nb[ret_reg] = 1'b0;
    // a fresh issue outranks a return to the same register
    if (iss_en && iss_reg != MAX_AW'(ZERO_REG))
      nb[iss_reg] = 1'b1;
    nb[ZERO_REG] = 1'b0;
    return nb;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb bus: read ports, writeback port, load issue/return.
// master drives requests, slave is the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic                     RegWriteEn;
  logic [ADDR_W-1:0]        WriteReg;
  logic [DATA_W-1:0]        WriteData;
  logic                     LdIssueEn;
  logic [ADDR_W-1:0]        LdIssueReg;
  logic                     LdRetValid;
  logic [ADDR_W-1:0]        LdRetReg;
  logic [DATA_W-1:0]        LdRetData;
  logic                     LdRetReady;
  logic [ADDR_W:0]          Outstanding;

  modport master (
    output RdAddr, RegWriteEn, WriteReg, WriteData,
    output LdIssueEn, LdIssueReg,
    output LdRetValid, LdRetReg, LdRetData,
    input  RdData, RdBusy, LdRetReady, Outstanding
  );

  modport slave (
    input  RdAddr, RegWriteEn, WriteReg, WriteData,
    input  LdIssueEn, LdIssueReg,
    input  LdRetValid, LdRetReg, LdRetData,
    output RdData, RdBusy, LdRetReady, Outstanding
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register load busy bits plus a registered
// count of busy registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_reg,
  input  logic                   ret_en,
  input  logic [ADDR_W-1:0]      ret_reg,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        Outstanding
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [MAX_DEPTH-1:0] busy_ext;
  logic [MAX_DEPTH-1:0] nb_full;
  logic [MAX_AW-1:0]    iss_ext;
  logic [MAX_AW-1:0]    ret_ext;
  logic                 unused_hi;
  logic                 set_one;
  logic                 clr_one;

  // widen state and addresses for the package helper
  always_comb begin
    busy_ext = '0;
    iss_ext  = '0;
    ret_ext  = '0;
    busy_ext[DEPTH-1:0]  = busy;
    iss_ext[ADDR_W-1:0]  = iss_reg;
    ret_ext[ADDR_W-1:0]  = ret_reg;
  end

  assign nb_full = next_busy(busy_ext, iss_en, iss_ext,
                             ret_en, ret_ext);
  assign unused_hi = ^nb_full[MAX_DEPTH-1:DEPTH];

  assign set_one = iss_en && (iss_reg != ZR) && !busy[iss_reg];
  assign clr_one = ret_en && (ret_reg != ZR) && busy[ret_reg]
                && !(iss_en && iss_reg == ret_reg);

  // busy bits and busy count, both cleared by reset
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      busy        <= '0;
      Outstanding <= '0;
    end else begin
      busy <= nb_full[DEPTH-1:0];
      if (set_one && !clr_one)
        Outstanding <= Outstanding + 1'b1;
      else if (clr_one && !set_one)
        Outstanding <= Outstanding - 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with load scoreboard.
// Same-cycle write bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input logic          Clk,
  input logic          RstN,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              ret_acc;
  logic              wb_wr;
  logic              ret_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // writeback owns the single write port; returns wait
  assign bus.LdRetReady = !bus.RegWriteEn;
  assign ret_acc = bus.LdRetValid && !bus.RegWriteEn;
  assign wb_wr   = bus.RegWriteEn && (bus.WriteReg != ZR);
  assign ret_wr  = ret_acc && (bus.LdRetReg != ZR);
  assign wr_en   = RstN && (wb_wr || ret_wr);
  assign wr_addr = wb_wr ? bus.WriteReg : bus.LdRetReg;
  assign wr_data = wb_wr ? bus.WriteData : bus.LdRetData;

  // storage array; entry 0 is never written
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .Clk         (Clk),
    .RstN        (RstN),
    .iss_en      (bus.LdIssueEn),
    .iss_reg     (bus.LdIssueReg),
    .ret_en      (ret_acc),
    .ret_reg     (bus.LdRetReg),
    .busy        (busy),
    .Outstanding (bus.Outstanding)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = bus.RdAddr[p*ADDR_W +: ADDR_W];

    // read mux per port, optionally forwarding this cycle's write
    always_comb begin
      d = (a == ZR) ? '0 : mem[a];
      b = busy[a];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && wr_addr == a)
        d = wr_data;
      if (RstN && ret_wr && bus.LdRetReg == a
          && !(bus.LdIssueEn && bus.LdIssueReg == a))
        b = 1'b0;
`endif
    end

    assign bus.RdData[p*DATA_W +: DATA_W] = d;
    assign bus.RdBusy[p] = b;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors for reg_file_sb, default or
// REG_FILE_BYPASS_EN build.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk;
  logic RstN;
  int   n_cmp;
  int   n_err;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  reg_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1);
    bus.RdAddr = {a1, a0};
  endtask

  function automatic logic [DW-1:0] rd0();
    return bus.RdData[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rd1();
    return bus.RdData[2*DW-1:DW];
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    RstN = 1'b0;
    bus.RdAddr     = '0;
    bus.RegWriteEn = 1'b0;
    bus.WriteReg   = '0;
    bus.WriteData  = '0;
    bus.LdIssueEn  = 1'b0;
    bus.LdIssueReg = '0;
    bus.LdRetValid = 1'b0;
    bus.LdRetReg   = '0;
    bus.LdRetData  = '0;

    // reset state
    rd(5, 5);
    #2;
    check("rst_rd0", rd0(), 0);
    check("rst_rd1", rd1(), 0);
    check("rst_busy", bus.RdBusy, 0);
    check("rst_out", bus.Outstanding, 0);
    #1 RstN = 1'b1;
    tick();

    // writes to reg 0 are dropped
    bus.RegWriteEn = 1'b1;
    bus.WriteReg   = 0;
    bus.WriteData  = 32'hDEADBEEF;
    rd(0, 0);
    #1 check("r0_same", rd0(), 0);
    tick();
    bus.RegWriteEn = 1'b0;
    #1 check("r0_after", rd1(), 0);

    // write reg 7, port 1 reads it
    bus.RegWriteEn = 1'b1;
    bus.WriteReg   = 7;
    bus.WriteData  = 32'h12345678;
    rd(0, 7);
    #1 check("r7_same", rd1(), BYP ? 32'h12345678 : 32'h0);
    tick();
    bus.RegWriteEn = 1'b0;
    #1 check("r7_next", rd1(), 32'h12345678);

    // load to reg 9, return stalled by writeback to reg 11
    bus.LdIssueEn  = 1'b1;
    bus.LdIssueReg = 9;
    tick();
    bus.LdIssueEn = 1'b0;
    rd(9, 11);
    #1;
    check("ld9_out", bus.Outstanding, 1);
    check("ld9_busy", bus.RdBusy[0], 1);
    bus.LdRetValid = 1'b1;
    bus.LdRetReg   = 9;
    bus.LdRetData  = 32'hCAFE0001;
    bus.RegWriteEn = 1'b1;
    bus.WriteReg   = 11;
    bus.WriteData  = 32'h11111111;
    #1;
    check("stall_rdy", bus.LdRetReady, 0);
    check("stall_rd0", rd0(), 0);
    check("stall_busy", bus.RdBusy[0], 1);
    tick();
    bus.RegWriteEn = 1'b0;
    #1;
    check("acc_rdy", bus.LdRetReady, 1);
    check("acc_rd0", rd0(), BYP ? 32'hCAFE0001 : 32'h0);
    check("acc_busy", bus.RdBusy[0], BYP ? 1'b0 : 1'b1);
    tick();
    bus.LdRetValid = 1'b0;
    #1;
    check("r9_data", rd0(), 32'hCAFE0001);
    check("r9_busy", bus.RdBusy[0], 0);
    check("r9_out", bus.Outstanding, 0);
    check("r11_data", rd1(), 32'h11111111);

    // reg 3: issue, then issue + return together
    bus.LdIssueEn  = 1'b1;
    bus.LdIssueReg = 3;
    tick();
    rd(3, 3);
    #1 check("r3_out1", bus.Outstanding, 1);
    bus.LdRetValid = 1'b1;
    bus.LdRetReg   = 3;
    bus.LdRetData  = 32'hA5A5A5A5;
    #1;
    check("r3_same_d", rd0(), BYP ? 32'hA5A5A5A5 : 32'h0);
    check("r3_same_b", bus.RdBusy[1], 1);
    tick();
    bus.LdRetValid = 1'b0;
    #1;
    check("r3_data", rd0(), 32'hA5A5A5A5);
    check("r3_busy", bus.RdBusy[0], 1);
    check("r3_out2", bus.Outstanding, 1);

    // re-issue to busy reg 3: no increment
    tick();
    bus.LdIssueEn = 1'b0;
    #1 check("reiss_out", bus.Outstanding, 1);

    // return to non-busy reg 12: written, no decrement
    bus.LdRetValid = 1'b1;
    bus.LdRetReg   = 12;
    bus.LdRetData  = 32'h00000012;
    tick();
    bus.LdRetValid = 1'b0;
    rd(12, 3);
    #1;
    check("r12_data", rd0(), 32'h00000012);
    check("r12_out", bus.Outstanding, 1);

    // loads to 2, 4, 6
    bus.LdIssueEn = 1'b1;
    for (int r = 2; r <= 6; r += 2) begin
      bus.LdIssueReg = AW'(r);
      tick();
    end
    bus.LdIssueEn = 1'b0;
    rd(2, 6);
    #1;
    check("multi_out", bus.Outstanding, 4);
    check("multi_busy", bus.RdBusy, 2'b11);

    // async reset mid-load, held across one edge with a write
    rd(3, 7);
    RstN = 1'b0;
    bus.RegWriteEn = 1'b1;
    bus.WriteReg   = 8;
    bus.WriteData  = 32'hFFFF0000;
    #1;
    check("mid_rd0", rd0(), 0);
    check("mid_rd1", rd1(), 0);
    check("mid_busy", bus.RdBusy, 0);
    check("mid_out", bus.Outstanding, 0);
    check("mid_rdy", bus.LdRetReady, 0);
    rd(8, 8);
    #1 check("mid_byp", rd0(), 0);
    @(posedge Clk);
    #2;
    bus.RegWriteEn = 1'b0;
    RstN = 1'b1;
    #1;
    check("post_r8", rd0(), 0);
    rd(2, 4);
    #1;
    check("post_rd0", rd0(), 0);
    check("post_busy", bus.RdBusy, 0);
    check("post_out", bus.Outstanding, 0);
    tick();
    check("post_out2", bus.Outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
